// File: rtl/arm_regfile_sb_pkg.sv
// Package arm_rf_pkg: default geometry of the ARM register file and the
// reset-value helper shared by the data array.
//   RF_DATA_W   : default register width
//   RF_ADDR_W   : default register address width
//   RF_NUM_REGS : default number of architectural registers (PC is external)
//   RF_NUM_RD   : default number of read ports
package arm_rf_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 4;
  localparam int RF_NUM_REGS = 15;
  localparam int RF_NUM_RD   = 3;

  // Reset contents of register idx: its own index, or zero when reset_idx is 0.
  function automatic logic [31:0] rf_reset_val(input int idx, input int reset_idx);
    logic [31:0] val_s;
    if (reset_idx != 0) begin
      val_s = 32'(idx);
    end else begin
      val_s = 32'd0;
    end
    return val_s;
  endfunction

endpackage

// File: rtl/arm_regfile_sb_scoreboard.sv
// rf_scoreboard: one pending bit per register plus per-read-port pending flags.
//   clk, rst           : clock, asynchronous active-low reset
//   claim_en/addr      : issue-time claim of a destination register
//   wa_en/addr, wb_en/addr : write-back ports, each clears the target's bit
//   rd_addr            : packed read addresses, ADDR_W bits per port
//   pend_vec           : registered pending bits
//   rd_pend            : per-port pending flag, masked by same-cycle write-back
module rf_scoreboard #(
  parameter int NUM_REGS = 15,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_REGS-1:0]      pend_vec,
  output logic [NUM_RD-1:0]        rd_pend
);

  // One extra bit so NUM_REGS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);

  logic [NUM_REGS-1:0] pend_r;

  // Pending bits: a claim beats a same-cycle write-back, otherwise a write clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r <= {NUM_REGS{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (claim_en && (claim_addr == ADDR_W'(i))) begin
          pend_r[i] <= 1'b1;
        end else if ((wa_en && (wa_addr == ADDR_W'(i))) || (wb_en && (wb_addr == ADDR_W'(i)))) begin
          pend_r[i] <= 1'b0;
        end else begin
          pend_r[i] <= pend_r[i];
        end
      end
    end
  end

  assign pend_vec = pend_r;

  for (genvar gk = 0; gk < NUM_RD; gk++) begin : g_pend
    logic [ADDR_W-1:0] ra_s;
    logic              pend_bit_s;

    assign ra_s = rd_addr[gk*ADDR_W +: ADDR_W];

    // Bypassed data is already valid, so a same-cycle write masks the pending bit.
    always_comb begin
      pend_bit_s = 1'b0;
      if (rst && ({1'b0, ra_s} < LIMIT)) begin
        pend_bit_s = pend_r[ra_s]
                   & ~(wa_en & (wa_addr == ra_s))
                   & ~(wb_en & (wb_addr == ra_s));
      end else begin
        pend_bit_s = 1'b0;
      end
    end

    assign rd_pend[gk] = pend_bit_s;
  end

endmodule

// File: rtl/arm_regfile_sb.sv
// arm_regfile_sb: ARM register file with write-to-read bypass and a register
// scoreboard.
//   clk, rst             : clock, asynchronous active-low reset
//   rd_addr / rd_data    : NUM_RD packed combinational read ports
//   rd_pend              : per-port "source has an outstanding claim"
//   wa_*                 : write port A (ALU/WB), wins over B on the same address
//   wb_*                 : write port B (load / base update)
//   claim_en/claim_addr  : destination claimed at issue
//   pend_vec             : registered pending bits
//   addr_err             : sticky flag for a write/claim to an address >= NUM_REGS
module arm_regfile_sb
  import arm_rf_pkg::*;
#(
  parameter int DATA_W    = RF_DATA_W,
  parameter int NUM_REGS  = RF_NUM_REGS,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int NUM_RD    = RF_NUM_RD,
  parameter int RESET_IDX = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [NUM_REGS-1:0]      pend_vec,
  output logic                     addr_err
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic              addr_err_r;
  logic              bad_access_s;

  assign bad_access_s = (wa_en    & ({1'b0, wa_addr}    >= LIMIT))
                      | (wb_en    & ({1'b0, wb_addr}    >= LIMIT))
                      | (claim_en & ({1'b0, claim_addr} >= LIMIT));

  // Data array: out-of-range addresses match no entry, so they never change state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= DATA_W'(rf_reset_val(i, RESET_IDX));
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wa_en && (wa_addr == ADDR_W'(i))) begin
          regs_r[i] <= wa_data;
        end else if (wb_en && (wb_addr == ADDR_W'(i))) begin
          regs_r[i] <= wb_data;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Sticky address error, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err_r <= 1'b0;
    end else begin
      addr_err_r <= addr_err_r | bad_access_s;
    end
  end

  assign addr_err = addr_err_r;

  for (genvar gk = 0; gk < NUM_RD; gk++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic [DATA_W-1:0] rdat_s;

    assign ra_s = rd_addr[gk*ADDR_W +: ADDR_W];

    // Read mux: A bypass, then B bypass, then array; no bypass while in reset.
    always_comb begin
      rdat_s = {DATA_W{1'b0}};
      if ({1'b0, ra_s} >= LIMIT) begin
        rdat_s = {DATA_W{1'b0}};
      end else if (rst && wa_en && (wa_addr == ra_s)) begin
        rdat_s = wa_data;
      end else if (rst && wb_en && (wb_addr == ra_s)) begin
        rdat_s = wb_data;
      end else begin
        rdat_s = regs_r[ra_s];
      end
    end

    assign rd_data[gk*DATA_W +: DATA_W] = rdat_s;
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .wa_en      (wa_en),
    .wa_addr    (wa_addr),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .rd_addr    (rd_addr),
    .pend_vec   (pend_vec),
    .rd_pend    (rd_pend)
  );

endmodule
